hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//   Pipeline interlock and flush sequencer for the 16-bit 5-stage core.
//   Sits beside the EX-stage forwarding logic and covers what forwarding cannot:
//   - load-use bubbles
//   - multi-cycle multiply occupancy of EX
//   - taken-branch flushes
//   Drives PC, IF/ID, ID/EX write enables, flushes and the EX/MEM bubble.
// PARAMETERS
//   REG_W       4   register-index width (16 architectural registers)
//   R_ZERO      0   index of the hard-wired zero register; never a hazard source
//   MUL_CYCLES  4   EX-stage occupancy of a multiply, in cycles; legal range 2..255
// PORTS
//   clk            in   1      core clock
//   rst            in   1      synchronous reset, active-high
//   ifid_rs        in   REG_W  source register A of the instruction in ID
//   ifid_rt        in   REG_W  source register B of the instruction in ID
//   ifid_uses_rt   in   1      ID instruction actually reads rt (0 for immediate forms)
//   idex_rt        in   REG_W  destination of a load currently in EX
//   idex_memread   in   1      instruction in EX is a load
//   idex_is_mul    in   1      instruction in EX is a multi-cycle multiply
//   branch_taken   in   1      branch in EX resolved taken this cycle
//   pc_write       out  1      PC update enable
//   ifid_write     out  1      IF/ID register load enable
//   ifid_flush     out  1      IF/ID register cleared to NOP
//   idex_write     out  1      ID/EX register load enable
//   idex_flush     out  1      ID/EX register cleared to NOP (bubble)
//   exmem_bubble   out  1      EX/MEM register loads a NOP instead of the EX result
//   busy           out  1      1 while the FSM is in MUL_BUSY
// BEHAVIOUR
//   State and counter are registered; outputs are combinational from state, cnt and inputs.
//   Reset: while rst=1, outputs are forced:
//     - pc_write=0, ifid_write=0, idex_write=0
//     - ifid_flush=1, idex_flush=1, exmem_bubble=1, busy=0
//   Next edge with rst=1: state<=RUN, cnt<=0. A reset mid-multiply abandons it immediately.
//   Default outputs (no hazard):
//     - pc_write=1, ifid_write=1, idex_write=1
//     - ifid_flush=0, idex_flush=0, exmem_bubble=0
//   State RUN, priority high to low:
//     1 branch_taken=1: ifid_flush=1, idex_flush=1; pc_write=1 (redirect).
//       Load-use and mul conditions are ignored.
//     2 idex_is_mul=1: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1.
//       cnt<=MUL_CYCLES-2; next state MUL_BUSY.
//     3 load-use: idex_memread=1, idex_rt!=R_ZERO, and idex_rt matches the ID source.
//       Match means idex_rt==ifid_rs, or ifid_uses_rt=1 and idex_rt==ifid_rt.
//       Response: pc_write=0, ifid_write=0, idex_flush=1 for exactly 1 cycle.
//       The load advances and the stalled ID instruction re-evaluates next cycle.
//   State MUL_BUSY (busy=1):
//     - cnt!=0: same stall outputs as RUN case 2; cnt<=cnt-1.
//     - cnt==0: default outputs; the multiply leaves EX; next state RUN.
//     - branch_taken and load-use inputs are ignored, since EX holds the multiply.
//   Timing: total stall = MUL_CYCLES-1 cycles; EX occupancy = MUL_CYCLES.
//   Back-to-back: a multiply entering EX on the release cycle is seen in RUN next cycle
//     and starts a fresh sequence.
//   Widths: cnt is 8 bits. Values of MUL_CYCLES outside 2..255 are rejected by elaboration check.
// CONFIGURATION
//   STALL_STATS_EN defined: adds output ports
//     - stall_cycles [15:0]: +1 each cycle pc_write=0 while rst=0
//     - flush_events [15:0]: +1 each cycle branch_taken flush fires
//     Both saturate at 16'hFFFF, clear to 0 on rst, update on the clk edge.
//   STALL_STATS_EN undefined: ports and counters absent; the remaining behaviour is identical.
// TESTING
//   1 rst=1 2 cycles -> pc_write=0, all flushes=1; first cycle after release -> default outputs, busy=0
//   2 idex_memread=1, idex_rt=5, ifid_rs=5 -> exactly 1 cycle of pc_write=0, idex_flush=1;
//     same with idex_rt=0 -> no stall; ifid_rt=5 with ifid_uses_rt=0 -> no stall
//   3 idex_is_mul=1 held, MUL_CYCLES=4 -> 3 cycles of pc_write=0, idex_write=0, exmem_bubble=1;
//     4th cycle default outputs; busy=1 for cycles 2-4
//   4 branch_taken=1 together with load-use match -> ifid_flush=1, idex_flush=1, pc_write=1
//   5 rst=1 asserted in 2nd cycle of multiply -> next cycle state RUN, busy=0, cnt=0
//   6 (STALL_STATS_EN) tests 2+3 -> stall_cycles=4; 2 branch flushes -> flush_events=2;
//     preload near max -> holds 16'hFFFF

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline interlock and flush sequencer for the 16-bit 5-stage core.
// Covers load-use bubbles, multi-cycle multiply occupancy of EX and
// taken-branch flushes, which the EX forwarding logic cannot resolve.
//
// Parameters:
//   REG_W      register-index width
//   R_ZERO     index of the hard-wired zero register
//   MUL_CYCLES EX occupancy of a multiply, 2..255
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   ifid_rs/rt    source registers of the instruction in ID
//   ifid_uses_rt  ID instruction reads rt
//   idex_rt       destination of the load in EX
//   idex_memread  EX instruction is a load
//   idex_is_mul   EX instruction is a multi-cycle multiply
//   branch_taken  branch in EX resolved taken
//   pc_write, ifid_write, idex_write     pipeline load enables
//   ifid_flush, idex_flush, exmem_bubble NOP insertion controls
//   busy          multiply sequence in progress
// Optional feature (macro STALL_STATS_EN):
//   stall_cycles, flush_events  saturating 16-bit event counters
module hazard_stall_controller #(
    parameter int REG_W      = 4,
    parameter int R_ZERO     = 0,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             idex_memread,
    input  logic             idex_is_mul,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             busy
`ifdef STALL_STATS_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      flush_events
`endif
);

    if (MUL_CYCLES < 2 || MUL_CYCLES > 255) begin : g_bad_mul_cycles
        $error("MUL_CYCLES must be in 2..255");
    end

    typedef enum logic {
        ST_RUN,
        ST_MUL_BUSY
    } state_t;

    // The first stall cycle happens in RUN, so the counter covers the rest.
    localparam logic [7:0] CNT_LOAD = 8'(MUL_CYCLES - 2);

    state_t     r_state;
    logic [7:0] r_cnt;

    logic w_load_use;
    logic w_branch_flush;

    assign w_load_use = idex_memread
                     && (idex_rt != REG_W'(R_ZERO))
                     && ((idex_rt == ifid_rs)
                      || (ifid_uses_rt && (idex_rt == ifid_rt)));

    assign w_branch_flush = !rst && (r_state == ST_RUN) && branch_taken;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        busy         = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (idex_is_mul) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                    end else if (w_load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                ST_MUL_BUSY: begin
                    busy = 1'b1;
                    // EX holds the multiply: branch and load-use are moot.
                    if (r_cnt != 8'd0) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!branch_taken && idex_is_mul) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_MUL_BUSY;
                    end
                end
                ST_MUL_BUSY: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef STALL_STATS_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 16'd0;
            r_flush_events <= 16'd0;
        end else begin
            if (!pc_write && r_stall_cycles != 16'hFFFF) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_branch_flush && r_flush_events != 16'hFFFF) begin
                r_flush_events <= r_flush_events + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed vectors push
// expected output vectors, a monitor pops and compares each cycle.
module tb_hazard_stall_controller;

    logic       clk;
    logic       rst;
    logic [3:0] ifid_rs;
    logic [3:0] ifid_rt;
    logic       ifid_uses_rt;
    logic [3:0] idex_rt;
    logic       idex_memread;
    logic       idex_is_mul;
    logic       branch_taken;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_write;
    logic       idex_flush;
    logic       exmem_bubble;
    logic       busy;
`ifdef STALL_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    hazard_stall_controller #(
        .REG_W(4),
        .R_ZERO(0),
        .MUL_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ifid_rs(ifid_rs),
        .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt),
        .idex_rt(idex_rt),
        .idex_memread(idex_memread),
        .idex_is_mul(idex_is_mul),
        .branch_taken(branch_taken),
        .pc_write(pc_write),
        .ifid_write(ifid_write),
        .ifid_flush(ifid_flush),
        .idex_write(idex_write),
        .idex_flush(idex_flush),
        .exmem_bubble(exmem_bubble),
        .busy(busy)
`ifdef STALL_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, busy}
    localparam logic [6:0] E_RST  = 7'b0010110;
    localparam logic [6:0] E_DEF  = 7'b1101000;
    localparam logic [6:0] E_DEFB = 7'b1101001;
    localparam logic [6:0] E_LU   = 7'b0001100;
    localparam logic [6:0] E_MUL  = 7'b0000010;
    localparam logic [6:0] E_MULB = 7'b0000011;
    localparam logic [6:0] E_BR   = 7'b1111100;

    typedef struct {
        logic [6:0] v;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Inputs change on the falling edge; the vector seen at the next rising
    // edge is the one the expectation describes.
    task automatic step(input logic r, input logic mr, input logic [3:0] xrt,
                        input logic [3:0] rs, input logic [3:0] rt,
                        input logic urt, input logic mul, input logic br,
                        input logic [6:0] e, input string name);
        exp_t x;
        @(negedge clk);
        rst          = r;
        idex_memread = mr;
        idex_rt      = xrt;
        ifid_rs      = rs;
        ifid_rt      = rt;
        ifid_uses_rt = urt;
        idex_is_mul  = mul;
        branch_taken = br;
        x.v          = e;
        x.name       = name;
        q.push_back(x);
    endtask

    task automatic idle(input logic [6:0] e, input string name);
        step(0, 0, 0, 0, 0, 0, 0, 0, e, name);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                x = q.pop_front();
                check(x.name,
                      {9'd0, pc_write, ifid_write, ifid_flush, idex_write,
                       idex_flush, exmem_bubble, busy},
                      {9'd0, x.v});
            end
        end
    end

    task automatic drain();
        int budget;
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        #4;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d left expected 0", q.size());
        end
    endtask

    initial begin : stim
        rst          = 1'b1;
        idex_memread = 1'b0;
        idex_rt      = '0;
        ifid_rs      = '0;
        ifid_rt      = '0;
        ifid_uses_rt = 1'b0;
        idex_is_mul  = 1'b0;
        branch_taken = 1'b0;

        // reset state and release
        step(1, 0, 0, 0, 0, 0, 0, 0, E_RST, "rst0");
        step(1, 1, 5, 5, 0, 0, 1, 1, E_RST, "rst1");
        idle(E_DEF, "release");

        // load-use
        step(0, 1, 5, 5, 0, 0, 0, 0, E_LU, "lu_rs");
        idle(E_DEF, "lu_done");
        step(0, 1, 0, 0, 0, 1, 0, 0, E_DEF, "lu_rzero");
        step(0, 1, 5, 3, 5, 0, 0, 0, E_DEF, "lu_rt_unused");
        step(0, 1, 5, 3, 5, 1, 0, 0, E_LU, "lu_rt_used");
        step(0, 1, 5, 3, 4, 1, 0, 0, E_DEF, "lu_nomatch");

        // multiply, branch and load-use ignored while busy
        step(0, 0, 0, 0, 0, 0, 1, 0, E_MUL, "mul_c1");
        step(0, 0, 0, 0, 0, 0, 1, 1, E_MULB, "mul_c2");
        step(0, 1, 5, 5, 0, 0, 1, 0, E_MULB, "mul_c3");
        step(0, 0, 0, 0, 0, 0, 1, 0, E_DEFB, "mul_c4");
        // back-to-back multiply seen in RUN
        step(0, 0, 0, 0, 0, 0, 1, 0, E_MUL, "mul2_c1");
        idle(E_MULB, "mul2_c2");
        idle(E_MULB, "mul2_c3");
        idle(E_DEFB, "mul2_c4");
        idle(E_DEF, "mul2_after");

        // branch priority
        step(0, 1, 5, 5, 0, 0, 0, 1, E_BR, "br_lu");
        step(0, 0, 0, 0, 0, 0, 1, 1, E_BR, "br_mul");
        idle(E_DEF, "br_after");

        // reset mid-multiply
        step(0, 0, 0, 0, 0, 0, 1, 0, E_MUL, "rmul_c1");
        step(1, 0, 0, 0, 0, 0, 1, 0, E_RST, "rmul_rst");
        idle(E_DEF, "rmul_after");
        drain();

`ifdef STALL_STATS_EN
        step(1, 0, 0, 0, 0, 0, 0, 0, E_RST, "st_rst");
        idle(E_DEF, "st_idle");
        drain();
        check("stall_clear", stall_cycles, 16'd0);
        check("flush_clear", flush_events, 16'd0);
        step(0, 1, 5, 5, 0, 0, 0, 0, E_LU, "st_lu");
        step(0, 0, 0, 0, 0, 0, 1, 0, E_MUL, "st_mul1");
        idle(E_MULB, "st_mul2");
        idle(E_MULB, "st_mul3");
        idle(E_DEFB, "st_mul4");
        idle(E_DEF, "st_after");
        drain();
        check("stall_cycles", stall_cycles, 16'd4);
        step(0, 0, 0, 0, 0, 0, 0, 1, E_BR, "st_br1");
        idle(E_DEF, "st_gap");
        step(0, 0, 0, 0, 0, 0, 0, 1, E_BR, "st_br2");
        idle(E_DEF, "st_br_after");
        drain();
        check("flush_events", flush_events, 16'd2);
        check("stall_kept", stall_cycles, 16'd4);
        // hold a load-use hazard long enough to saturate
        @(negedge clk);
        idex_memread = 1'b1;
        idex_rt      = 4'd7;
        ifid_rs      = 4'd7;
        repeat (65540) @(negedge clk);
        #3;
        check("stall_sat", stall_cycles, 16'hFFFF);
        @(negedge clk);
        idex_memread = 1'b0;
        #3;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
